// File: rtl/digit_scan_ctrl_pkg.sv
// Shared definitions for the 4-digit display scan controller:
// state encoding, digit geometry and the slot-counter width helper.
package digit_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } scan_state_t;

    localparam int DIGIT_CNT = 4;
    localparam int NIB_W     = 4;
    localparam int SEL_W     = 2;

    function automatic int cnt_width(input int div);
        return ($clog2(div) < 1) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/digit_scan_ctrl_if.sv
// Control/data bundle between the scan controller and its host:
// run level and digit data in, decoder select/enable and nibble out.
interface digit_scan_ctrl_if;
    import digit_scan_ctrl_pkg::*;

    logic                         run;
    logic [DIGIT_CNT*NIB_W-1:0]   digits;
    logic [DIGIT_CNT-1:0]         dmask;
    logic [SEL_W-1:0]             sel;
    logic                         en;
    logic [NIB_W-1:0]             nibble;
    logic                         frame_tick;

    modport master (
        output run, digits, dmask,
        input  sel, en, nibble, frame_tick
    );

    modport slave (
        input  run, digits, dmask,
        output sel, en, nibble, frame_tick
    );

endinterface

// File: rtl/digit_scan_ctrl_slot_timer.sv
// Modulo-CLK_DIV slot counter; flags the last blanking cycle and the last slot cycle.
module digit_scan_ctrl_slot_timer
    import digit_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_blank_done,
    output logic o_slot_done
);

    localparam int                CNT_W         = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0]  LP_SLOT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0]  LP_BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    logic [CNT_W-1:0] r_cnt;

    assign o_slot_done  = (r_cnt == LP_SLOT_LAST);
    // With no blanking window the BLANK state is never entered, so the flag stays low.
    assign o_blank_done = (BLANK_CYC != 0) && (r_cnt == LP_BLANK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= o_slot_done ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit scan controller driving a 2-to-4 decoder, with
// per-slot blanking and a once-per-frame shadow of the digit data and mask.
module digit_scan_ctrl
    import digit_scan_ctrl_pkg::*;
#(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    digit_scan_ctrl_if.slave  bus
);

    localparam scan_state_t LP_SLOT_START = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
    localparam logic        LP_NO_BLANK   = (BLANK_CYC == 0);

    scan_state_t                 r_state;
    logic [SEL_W-1:0]            r_sel;
    logic                        r_en;
    logic                        r_tick;
    logic [NIB_W-1:0]            r_nibble;
    logic [DIGIT_CNT*NIB_W-1:0]  r_shadow_dig;
    logic [DIGIT_CNT-1:0]        r_shadow_mask;

    logic                        w_clr;
    logic                        w_inc;
    logic                        w_blank_done;
    logic                        w_slot_done;
    logic [SEL_W-1:0]            w_sel_nxt;
    logic                        w_wrap;
    logic [DIGIT_CNT*NIB_W-1:0]  w_dig_nxt;
    logic [DIGIT_CNT-1:0]        w_mask_nxt;

    // Counter is held at zero whenever scanning is stopped or about to stop.
    assign w_clr = (r_state == ST_IDLE) || !bus.run;
    assign w_inc = (r_state != ST_IDLE);

    digit_scan_ctrl_slot_timer #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .i_clr        (w_clr),
        .i_inc        (w_inc),
        .o_blank_done (w_blank_done),
        .o_slot_done  (w_slot_done)
    );

    // A frame boundary is either a fresh start from IDLE or the 3->0 wrap; both reload the shadow.
    assign w_wrap     = (r_state == ST_IDLE) || (r_sel == SEL_W'(DIGIT_CNT - 1));
    assign w_sel_nxt  = (r_state == ST_IDLE) ? '0 : r_sel + 1'b1;
    assign w_dig_nxt  = w_wrap ? bus.digits : r_shadow_dig;
    assign w_mask_nxt = w_wrap ? bus.dmask  : r_shadow_mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_en          <= 1'b0;
            r_tick        <= 1'b0;
            r_nibble      <= '0;
            r_shadow_dig  <= '0;
            r_shadow_mask <= '0;
        end else begin
            r_tick <= 1'b0;
            case (r_state)
                ST_IDLE, ST_BLANK, ST_SHOW: begin
                    if ((r_state != ST_IDLE) && !bus.run) begin
                        r_state <= ST_IDLE;
                        r_en    <= 1'b0;
                    end else if ((r_state == ST_IDLE && bus.run) ||
                                 (r_state != ST_IDLE && w_slot_done)) begin
                        r_state  <= LP_SLOT_START;
                        r_sel    <= w_sel_nxt;
                        r_nibble <= w_dig_nxt[NIB_W*w_sel_nxt +: NIB_W];
                        // en drops on the select change unless there is no blanking window.
                        r_en     <= LP_NO_BLANK && w_mask_nxt[w_sel_nxt];
                        if (w_wrap) begin
                            r_shadow_dig  <= bus.digits;
                            r_shadow_mask <= bus.dmask;
                            r_tick        <= 1'b1;
                        end
                    end else if (r_state == ST_BLANK && w_blank_done) begin
                        r_state <= ST_SHOW;
                        r_en    <= r_shadow_mask[r_sel];
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_en    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel        = r_sel;
    assign bus.en         = r_en;
    assign bus.nibble     = r_nibble;
    assign bus.frame_tick = r_tick;

endmodule

// File: doc/digit_scan_ctrl.md
# digit_scan_ctrl

Time-multiplexed scan controller for a 4-digit display. It sits directly upstream of the 2-to-4 `decoder_24`, driving its `a` select and `en` inputs. It also presents the 4-bit value for the currently selected digit to the downstream segment encoder. A prescaler paces each digit slot, a blanking window at the start of every slot suppresses ghosting, and digit data is shadowed once per frame so a display update never tears mid-frame.

## Interface
- `CLK_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, default 8: cycles at slot start with `en` forced low; legal range 0 ≤ `BLANK_CYC` < `CLK_DIV`.
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `run`  in  1  level; 1 = scan, 0 = stop and blank.
- `digits`  in  16  four nibbles; digit *i* = `digits[4i+3:4i]`.
- `dmask`  in  4  per-digit enable; 0 = digit stays dark (leading-zero blanking).
- `sel`  out  2  digit index; connects to `decoder_24.a`.
- `en`  out  1  drive enable; connects to `decoder_24.en`.
- `nibble`  out  4  value of digit `sel` from the shadow register.
- `frame_tick`  out  1  one-cycle pulse when a new frame starts (`sel` wraps to 0).

## Operation
- States: IDLE, BLANK, SHOW. Slot counter `cnt` counts 0..`CLK_DIV`-1.
- All outputs are registered.
- Reset values: state=IDLE, `cnt`=0, `sel`=0, `en`=0, `nibble`=0, `frame_tick`=0, shadow digits/mask=0.
- IDLE→BLANK on an edge with `run`=1. On that edge: `cnt`←0, `sel`←0, shadow←`digits`/`dmask`, `frame_tick`←1.
  - If `BLANK_CYC`=0, the target state is SHOW instead of BLANK.
- BLANK: `en`=0, `cnt` increments. When `cnt`==`BLANK_CYC`-1 → SHOW.
- SHOW: `en`=shadow_mask[`sel`], `cnt` increments. When `cnt`==`CLK_DIV`-1:
  - `cnt`←0, `sel`←`sel`+1 (3 wraps to 0), state→BLANK (or SHOW if `BLANK_CYC`=0).
  - On the wrap to 0, the shadow reloads from the live inputs and `frame_tick` pulses for that one cycle.
- `nibble` always equals shadow[4·`sel`+:4] in the same cycle as `sel` (registered together).
- `run`=0 sampled in BLANK or SHOW:
  - next state is IDLE and `en`←0 on that edge;
  - `sel`, `nibble` and the shadow hold;
  - `cnt`←0.
- Re-asserting `run` always restarts at digit 0 with a fresh shadow.
- Input changes to `digits`/`dmask` mid-frame have no visible effect until the next frame boundary.

## Timing
- Slot length is exactly `CLK_DIV` cycles: `BLANK_CYC` cycles with `en`=0, then `CLK_DIV`-`BLANK_CYC` cycles with `en`=mask.
- Frame length is 4·`CLK_DIV` cycles.
- Latency:
  - `run` sampled high at edge k → `sel`=0 and `frame_tick`=1 are visible after edge k.
  - First `en`=1 appears after edge k+`BLANK_CYC`.
- `en` falls on the same edge that `sel` changes, so the decoder never sees a select change while enabled (unless `BLANK_CYC`=0).
- `frame_tick` is high for exactly one cycle per frame and never while in IDLE.
- Async `rst` mid-slot immediately forces all outputs to reset values. Scanning resumes only on the first edge after `rst` deasserts with `run`=1.

## Structure
- Shared include `scan_defs.vh` holds the state encoding localparams (IDLE=2'd0, BLANK=2'd1, SHOW=2'd2) and the counter width function (clog2 of `CLK_DIV`).
- One sub-module, `slot_timer`, is natural. It is a parameterised modulo-`CLK_DIV` counter with `clr` and `inc` inputs, and outputs `cnt`, `blank_done` (`cnt`==`BLANK_CYC`-1) and `slot_done` (`cnt`==`CLK_DIV`-1).
- The FSM, shadow registers and output muxing live in the top module.
- `decoder_24` is instantiated by the parent, not inside this block.

## Test plan
All scenarios use `CLK_DIV`=10 and `BLANK_CYC`=2 unless stated.
- Reset then `run`=1, `digits`=16'h4321, `dmask`=4'hF:
  - `sel` steps 0,1,2,3,0 every 10 cycles;
  - `nibble` = 1,2,3,4;
  - `en` is low for 2 cycles then high for 8 in each slot;
  - `frame_tick` pulses every 40 cycles.
- `dmask`=4'b0101: `en` stays low for all of slots 1 and 3; slots 0 and 2 behave normally.
- Change `digits` to 16'hABCD while `sel`=1: `nibble` shows 2,3,4 for the rest of the frame, then D,C,B,A from the next frame.
- Drop `run` while `sel`=2 in SHOW:
  - next cycle `en`=0, `sel` holds at 2, `frame_tick` stays 0;
  - re-raise `run`: `sel`=0, `frame_tick`=1, first `en`=1 two cycles later.
- Assert `rst` for one cycle mid-slot: all outputs go to 0 asynchronously, before the next clock edge.
- `BLANK_CYC`=0: `en` stays high continuously across slot boundaries; `sel` still changes every 10 cycles.
